// File: rtl/status_update_unit.sv
// rtl/status_update_unit.sv - status row update: way select (hit / first-invalid / tree-PLRU) and row write-back.
// Optional STATUS_UPDATE_FWD_EN forwards the last updated row to a back-to-back request for the same set.
module status_update_unit #(
  parameter int TAG_WIDTH  = 1,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_WAYS   = 4,
  localparam int ROW_WIDTH = 2 * NUM_WAYS - 1,
  localparam int WAY_W     = $clog2(NUM_WAYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_halt,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [ROW_WIDTH-1:0]  i_row,
  input  logic                  i_hit,
  input  logic [WAY_W-1:0]      i_hit_way,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [TAG_WIDTH-1:0]  o_tag,
  output logic [WAY_W-1:0]      o_way,
  output logic                  o_hit,
  output logic                  o_valid,
  output logic [ADDR_WIDTH-1:0] o_wb_addr,
  output logic [ROW_WIDTH-1:0]  o_wb_data,
  output logic                  o_wb_valid,
  input  logic                  i_wb_ready
);

  logic                  valid_q, valid_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [WAY_W-1:0]      way_q, way_d;
  logic                  hit_q, hit_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [ROW_WIDTH-1:0]  wb_data_q, wb_data_d;

  logic                  accept;
  logic [ROW_WIDTH-1:0]  row_src;
  logic [NUM_WAYS-1:0]   vld, vld_new;
  logic [NUM_WAYS-2:0]   plru, plru_new;
  logic [WAY_W-1:0]      inv_way, plru_way, way_sel;
  logic                  any_inv;

  assign o_ready = ~i_halt & ~(wb_valid_q & ~i_wb_ready);
  assign accept  = i_valid & o_ready;

`ifdef STATUS_UPDATE_FWD_EN
  logic fwd_vld_q, fwd_vld_d;

  // Output stage holds the freshest copy of its set; the array read is stale.
  always_comb begin
    fwd_vld_d = fwd_vld_q | accept;
    row_src   = (fwd_vld_q && (i_addr == wb_addr_q)) ? wb_data_q : i_row;
  end

  always_ff @(posedge clk) begin
    if (rst) fwd_vld_q <= 1'b0;
    else     fwd_vld_q <= fwd_vld_d;
  end
`else
  assign row_src = i_row;
`endif

  always_comb begin
    int node_v;
    int node_t;
    logic dir;
    vld      = row_src[NUM_WAYS-1:0];
    plru     = row_src[ROW_WIDTH-1:NUM_WAYS];
    inv_way  = '0;
    any_inv  = 1'b0;
    // Descending scan so the lowest-index invalid way wins.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!vld[w]) begin
        inv_way = WAY_W'(w);
        any_inv = 1'b1;
      end
    end
    node_v = 0;
    for (int l = 0; l < WAY_W; l++) begin
      node_v = 2 * node_v + 1 + int'(plru[node_v]);
    end
    plru_way = WAY_W'(node_v - (NUM_WAYS - 1));
    if (i_hit)        way_sel = i_hit_way;
    else if (any_inv) way_sel = inv_way;
    else              way_sel = plru_way;
    plru_new = plru;
    node_t   = 0;
    for (int l = 0; l < WAY_W; l++) begin
      dir              = way_sel[WAY_W-1-l];
      plru_new[node_t] = ~dir;
      node_t           = 2 * node_t + 1 + int'(dir);
    end
    vld_new = vld;
    if (!i_hit) vld_new[way_sel] = 1'b1;
  end

  always_comb begin
    valid_d    = valid_q;
    wb_valid_d = wb_valid_q;
    tag_d      = tag_q;
    way_d      = way_q;
    hit_d      = hit_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    if (!i_halt) valid_d = accept;
    if (wb_valid_q && i_wb_ready) wb_valid_d = 1'b0;
    if (accept) begin
      wb_valid_d = 1'b1;
      tag_d      = i_tag;
      way_d      = way_sel;
      hit_d      = i_hit;
      wb_addr_d  = i_addr;
      wb_data_d  = {plru_new, vld_new};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      tag_q      <= '0;
      way_q      <= '0;
      hit_q      <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      wb_valid_q <= wb_valid_d;
      tag_q      <= tag_d;
      way_q      <= way_d;
      hit_q      <= hit_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // A result held across a halt is presented once the halt lifts.
  assign o_valid    = valid_q & ~i_halt;
  assign o_wb_valid = wb_valid_q;
  assign o_tag      = tag_q;
  assign o_way      = way_q;
  assign o_hit      = hit_q;
  assign o_wb_addr  = wb_addr_q;
  assign o_wb_data  = wb_data_q;

endmodule
